decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered instruction-decode stage for the 16-bit CPU. Sits between fetch and execute.
//  Decodes opcode/register fields into a control bundle and holds it in one pipeline register.
//  Uses a valid/ready handshake on both sides. Detects load-use hazards with a one-entry
//  load scoreboard. Flags illegal opcodes.
// PARAMETERS
//  REG_AW    4  register-index width; INSTR_W = 4 + 3*REG_AW (opcode always 4 bits)
//  LOAD_LAT  2  cycles after LDR issue before its Rd may be read (>=1)
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  in_instr    in   INSTR_W  {op[4], rd, rs1, rs2}; imm8 = {rd, rs1} when REG_AW=4
//  in_valid    in   1        fetch has an instruction
//  in_ready    out  1        decode accepts in_instr this cycle
//  flush       in   1        discard the held instruction (branch taken)
//  out_valid   out  1        control bundle valid
//  out_ready   in   1        execute consumes the bundle
//  out_rd/rs1/rs2 out REG_AW registered register fields
//  out_imm     out  2*REG_AW registered immediate field
//  reg_src     out  2        [0]=srcA is zero (NEG), [1]=read rd as port-2 (STR)
//  imm_src     out  2        00 imm8 zero-ext, 01 mem offset, 10 branch offset
//  alu_src     out  1        1 = ALU B from immediate
//  alu_op      out  3        000 add, 001 sub, 010 pass B, 011 shift left
//  flag_w      out  2        flag write enables {NZ, CV}
//  br_cond     out  2        00 EQ, 01 GT, 10 LT, 11 always
//  pcs, reg_w, mem_w, mem_to_reg, illegal  out  1 each
// BEHAVIOUR
//  Opcode table (unlisted fields are 0):
//  - 0 ADD: reg_w, alu_op=000, flag_w=11. Reads rs1, rs2.
//  - 1 SUB: as ADD with alu_op=001.
//  - A NEG: reg_w, reg_src[0], alu_op=001, flag_w=11. Reads rs2.
//  - 2/3/4/5 BEQ/BGT/BLT/B: pcs, alu_src, imm_src=10, br_cond=00/01/10/11. Read nothing.
//  - 6 MOV: reg_w, alu_src, imm_src=00, alu_op=010. Reads nothing.
//  - 7 LDR: reg_w, alu_src, imm_src=01, mem_to_reg. Reads rs1.
//  - 8 LSL: reg_w, alu_op=011. Reads rs1, rs2.
//  - 9 STR: mem_w, alu_src, imm_src=01, reg_src[1]. Reads rs1, rd.
//  - B-F: illegal=1, and reg_w, mem_w, pcs, flag_w forced to 0. The bundle still flows.
//  Pipeline register:
//  - issue = in_valid & in_ready. On issue, the decoded bundle is loaded and out_valid=1 next cycle.
//  - Latency is 1 cycle. Throughput is 1 per cycle when there is no stall.
//  - in_ready = (!out_valid | out_ready) & !hazard & !flush.
//  - out_valid & !out_ready: all outputs hold stable.
//  - out_valid clears when consumed with no new issue.
//  Scoreboard (ld_pend, ld_rd, ld_cnt):
//  - LDR issue sets ld_pend=1, ld_rd=rd, ld_cnt=LOAD_LAT.
//  - While ld_pend is set, ld_cnt decrements every cycle. At ld_cnt==1, ld_pend clears at that edge.
//  - hazard = ld_pend & (any register read by in_instr == ld_rd, or in_instr is LDR).
//  - A new LDR issuing in the same cycle the old entry expires reloads the entry; the new load wins.
//  - Reads of register index 0 are still checked; there is no special case.
//  flush:
//  - Next edge: out_valid=0 and no issue in the flush cycle.
//  - The scoreboard is NOT cleared, because an issued load is already in flight.
//  - flush together with out_ready: flush wins and the bundle is dropped.
//  Reset (async assert, sync release):
//  - out_valid=0, ld_pend=0, ld_cnt=0, ld_rd=0.
//  - All bundle outputs are 0. in_ready=1 after release.
//  - Reset mid-stall drops the held instruction and the scoreboard.
// TESTING
//  1. Reset, then ADD r1,r2,r3 (0x0123) valid, out_ready=1:
//     next cycle out_valid=1, reg_w=1, alu_op=000, flag_w=11, rd=1.
//  2. Stream ADD, SUB, MOV, LSL on consecutive cycles:
//     one bundle per cycle, in_ready held 1, fields match the table.
//  3. LOAD_LAT=2. LDR r3 (0x73xx), then ADD r4,r3,r1 (0x0431):
//     ADD stalls 2 cycles (in_ready=0), then issues. ADD r4,r5,r6 instead: no stall.
//  4. out_ready=0 for 3 cycles with a bundle held:
//     outputs stable, in_ready=0. Release: next bundle follows in the next cycle.
//  5. Bundle held plus flush=1 with out_ready=1:
//     next cycle out_valid=0. A pending LDR scoreboard entry still stalls a reader of ld_rd.
//  6. Opcode 0xF, then STR r3 (0x93xx) after LDR r3:
//     illegal=1 with reg_w=mem_w=pcs=0; the STR stalls on the rd read.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage between fetch and execute.
// Decodes {op, rd, rs1, rs2} into a control bundle held in one pipeline register,
// with valid/ready on both sides, a one-entry load scoreboard for load-use stalls,
// and an illegal-opcode flag.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_instr, in_valid         instruction from fetch
//   in_ready                   decode accepts in_instr this cycle (combinational)
//   flush                      drop the held bundle, block issue this cycle
//   out_valid, out_ready       bundle handshake toward execute
//   out_rd/out_rs1/out_rs2     registered register fields
//   out_imm                    registered immediate {rd, rs1}
//   reg_src..illegal           registered control bundle
module decode_stage #(
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned LOAD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4+3*REG_AW-1:0] in_instr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_AW-1:0]     out_rd,
  output logic [REG_AW-1:0]     out_rs1,
  output logic [REG_AW-1:0]     out_rs2,
  output logic [2*REG_AW-1:0]   out_imm,
  output logic [1:0]            reg_src,
  output logic [1:0]            imm_src,
  output logic                  alu_src,
  output logic [2:0]            alu_op,
  output logic [1:0]            flag_w,
  output logic [1:0]            br_cond,
  output logic                  pcs,
  output logic                  reg_w,
  output logic                  mem_w,
  output logic                  mem_to_reg,
  output logic                  illegal
);

  localparam int unsigned INSTR_W = 4 + 3*REG_AW;
  localparam int unsigned IMM_W   = 2*REG_AW;
  localparam int unsigned CNT_W   = $clog2(LOAD_LAT + 1);

  typedef struct packed {
    logic [1:0] reg_src;
    logic [1:0] imm_src;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [1:0] flag_w;
    logic [1:0] br_cond;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       illegal;
  } ctrl_t;

  // Instruction field split
  logic [3:0]        op_c;
  logic [REG_AW-1:0] rd_c, rs1_c, rs2_c;
  logic [IMM_W-1:0]  imm_c;

  assign op_c  = in_instr[INSTR_W-1 -: 4];
  assign rd_c  = in_instr[3*REG_AW-1 -: REG_AW];
  assign rs1_c = in_instr[2*REG_AW-1 -: REG_AW];
  assign rs2_c = in_instr[REG_AW-1:0];
  assign imm_c = in_instr[3*REG_AW-1 -: IMM_W];

  // Opcode decode: control bundle plus which register fields are read
  ctrl_t dec_c;
  logic  use_rd_c, use_rs1_c, use_rs2_c, is_ldr_c;

  always_comb begin
    dec_c     = '0;
    use_rd_c  = 1'b0;
    use_rs1_c = 1'b0;
    use_rs2_c = 1'b0;
    is_ldr_c  = 1'b0;
    case (op_c)
      4'h0: begin
        dec_c.reg_w  = 1'b1;
        dec_c.flag_w = 2'b11;
        use_rs1_c    = 1'b1;
        use_rs2_c    = 1'b1;
      end
      4'h1: begin
        dec_c.reg_w  = 1'b1;
        dec_c.alu_op = 3'b001;
        dec_c.flag_w = 2'b11;
        use_rs1_c    = 1'b1;
        use_rs2_c    = 1'b1;
      end
      4'hA: begin
        dec_c.reg_w   = 1'b1;
        dec_c.reg_src = 2'b01;
        dec_c.alu_op  = 3'b001;
        dec_c.flag_w  = 2'b11;
        use_rs2_c     = 1'b1;
      end
      4'h2, 4'h3, 4'h4, 4'h5: begin
        dec_c.pcs     = 1'b1;
        dec_c.alu_src = 1'b1;
        dec_c.imm_src = 2'b10;
        dec_c.br_cond = 2'(op_c - 4'h2);
      end
      4'h6: begin
        dec_c.reg_w   = 1'b1;
        dec_c.alu_src = 1'b1;
        dec_c.alu_op  = 3'b010;
      end
      4'h7: begin
        dec_c.reg_w      = 1'b1;
        dec_c.alu_src    = 1'b1;
        dec_c.imm_src    = 2'b01;
        dec_c.mem_to_reg = 1'b1;
        use_rs1_c        = 1'b1;
        is_ldr_c         = 1'b1;
      end
      4'h8: begin
        dec_c.reg_w  = 1'b1;
        dec_c.alu_op = 3'b011;
        use_rs1_c    = 1'b1;
        use_rs2_c    = 1'b1;
      end
      4'h9: begin
        dec_c.mem_w   = 1'b1;
        dec_c.alu_src = 1'b1;
        dec_c.imm_src = 2'b01;
        dec_c.reg_src = 2'b10;
        use_rs1_c     = 1'b1;
        use_rd_c      = 1'b1;
      end
      default: begin
        // Illegal opcodes still flow, but with every side effect suppressed
        dec_c.illegal = 1'b1;
      end
    endcase
  end

  // Load scoreboard state
  logic              ld_pend;
  logic [REG_AW-1:0] ld_rd;
  logic [CNT_W-1:0]  ld_cnt;

  // Stall a reader of the in-flight load target, or a second load (one entry only).
  // Register 0 is checked like any other index.
  logic hazard_c, issue_c;

  assign hazard_c = ld_pend & ((use_rd_c  & (rd_c  == ld_rd)) |
                               (use_rs1_c & (rs1_c == ld_rd)) |
                               (use_rs2_c & (rs2_c == ld_rd)) |
                               is_ldr_c);
  assign in_ready = (~out_valid | out_ready) & ~hazard_c & ~flush;
  assign issue_c  = in_valid & in_ready;

  // Pipeline register; fields hold while stalled or after the bundle leaves
  ctrl_t ctrl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      out_rd    <= '0;
      out_rs1   <= '0;
      out_rs2   <= '0;
      out_imm   <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (issue_c) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (issue_c) begin
        ctrl_q  <= dec_c;
        out_rd  <= rd_c;
        out_rs1 <= rs1_c;
        out_rs2 <= rs2_c;
        out_imm <= imm_c;
      end
    end
  end

  // Scoreboard: a newly issued load always reloads the entry.
  // flush leaves it alone since the issued load is already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_pend <= 1'b0;
      ld_rd   <= '0;
      ld_cnt  <= '0;
    end else if (issue_c && is_ldr_c) begin
      ld_pend <= 1'b1;
      ld_rd   <= rd_c;
      ld_cnt  <= CNT_W'(LOAD_LAT);
    end else if (ld_pend) begin
      ld_cnt <= ld_cnt - CNT_W'(1);
      if (ld_cnt == CNT_W'(1)) begin
        ld_pend <= 1'b0;
      end
    end
  end

  assign reg_src    = ctrl_q.reg_src;
  assign imm_src    = ctrl_q.imm_src;
  assign alu_src    = ctrl_q.alu_src;
  assign alu_op     = ctrl_q.alu_op;
  assign flag_w     = ctrl_q.flag_w;
  assign br_cond    = ctrl_q.br_cond;
  assign pcs        = ctrl_q.pcs;
  assign reg_w      = ctrl_q.reg_w;
  assign mem_w      = ctrl_q.mem_w;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven decode checks plus directed stall/hold/flush/reset sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_rd, out_rs1, out_rs2;
  logic [7:0]  out_imm;
  logic [1:0]  reg_src, imm_src, flag_w, br_cond;
  logic        alu_src, pcs, reg_w, mem_w, mem_to_reg, illegal;
  logic [2:0]  alu_op;

  decode_stage #(.REG_AW(4), .LOAD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .reg_src(reg_src), .imm_src(imm_src), .alu_src(alu_src), .alu_op(alu_op),
    .flag_w(flag_w), .br_cond(br_cond), .pcs(pcs), .reg_w(reg_w),
    .mem_w(mem_w), .mem_to_reg(mem_to_reg), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [16:0] bund;
  assign bund = {reg_src, imm_src, alu_src, alu_op, flag_w, br_cond,
                 pcs, reg_w, mem_w, mem_to_reg, illegal};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [16:0] mk(input logic [1:0] rs, input logic [1:0] is,
                                     input logic as, input logic [2:0] ao,
                                     input logic [1:0] fw, input logic [1:0] bc,
                                     input logic p, input logic rw, input logic mw,
                                     input logic m2r, input logic ill);
    return {rs, is, as, ao, fw, bc, p, rw, mw, m2r, ill};
  endfunction

  function automatic logic [19:0] flds(input logic [15:0] ins);
    return {ins[11:8], ins[7:4], ins[3:0], ins[11:4]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count cycles with in_ready low, bounded
  task automatic count_stall(output int n);
    n = 0;
    #1;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [16:0] exp;
    string       name;
  } vec_t;

  vec_t tab[13];

  logic [16:0] e_add, e_sub, e_ill;
  int          n;

  initial begin
    e_add = mk(2'd0, 2'd0, 1'b0, 3'd0, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e_sub = mk(2'd0, 2'd0, 1'b0, 3'd1, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e_ill = mk(2'd0, 2'd0, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tab[0]  = '{16'h0123, e_add, "ADD"};
    tab[1]  = '{16'h1456, e_sub, "SUB"};
    tab[2]  = '{16'h6ab0, mk(2'd0, 2'd0, 1'b1, 3'd2, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "MOV"};
    tab[3]  = '{16'h8789, mk(2'd0, 2'd0, 1'b0, 3'd3, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "LSL"};
    tab[4]  = '{16'ha0c5, mk(2'd1, 2'd0, 1'b0, 3'd1, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "NEG"};
    tab[5]  = '{16'h2123, mk(2'd0, 2'd2, 1'b1, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "BEQ"};
    tab[6]  = '{16'h3456, mk(2'd0, 2'd2, 1'b1, 3'd0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "BGT"};
    tab[7]  = '{16'h4789, mk(2'd0, 2'd2, 1'b1, 3'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "BLT"};
    tab[8]  = '{16'h5abc, mk(2'd0, 2'd2, 1'b1, 3'd0, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "B"};
    tab[9]  = '{16'h9312, mk(2'd2, 2'd1, 1'b1, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "STR"};
    tab[10] = '{16'hb111, e_ill, "ILL_B"};
    tab[11] = '{16'hf123, e_ill, "ILL_F"};
    tab[12] = '{16'h7312, mk(2'd0, 2'd1, 1'b1, 3'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), "LDR"};

    rst_n = 1'b0; in_instr = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #22;
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bundle", 32'(bund), 32'd0);
    chk("rst_fields", 32'({out_rd, out_rs1, out_rs2, out_imm}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back stream through the opcode table
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      in_instr = tab[i].instr;
      in_valid = 1'b1;
      #1;
      chk({"rdy_", tab[i].name}, 32'(in_ready), 32'd1);
      step();
      chk({"vld_", tab[i].name}, 32'(out_valid), 32'd1);
      chk({"bund_", tab[i].name}, 32'(bund), 32'(tab[i].exp));
      chk({"flds_", tab[i].name}, 32'({out_rd, out_rs1, out_rs2, out_imm}), 32'(flds(tab[i].instr)));
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    step(); step();

    // Load-use: LDR r3 then ADD r4,r3,r1 stalls two cycles
    in_instr = 16'h7310; in_valid = 1'b1;
    step();
    in_instr = 16'h0431;
    count_stall(n);
    chk("ldr_use_stall", 32'(n), 32'd2);
    step();
    chk("ldr_use_valid", 32'(out_valid), 32'd1);
    chk("ldr_use_bund", 32'(bund), 32'(e_add));
    chk("ldr_use_rd", 32'(out_rd), 32'd4);

    // Load then independent ADD r4,r5,r6: no stall
    in_instr = 16'h7310;
    step();
    in_instr = 16'h0456;
    #1;
    chk("ldr_nodep_rdy", 32'(in_ready), 32'd1);
    step();
    chk("ldr_nodep_rs1", 32'(out_rs1), 32'd5);
    in_valid = 1'b0;
    step(); step();

    // Register 0 is hazard-checked too
    in_instr = 16'h7000; in_valid = 1'b1;
    step();
    in_instr = 16'h0120;
    count_stall(n);
    chk("r0_stall", 32'(n), 32'd2);
    in_valid = 1'b0;
    step(); step();

    // Back-pressure: held bundle stays stable for 3 cycles, then next follows
    out_ready = 1'b0;
    in_instr = 16'h0123; in_valid = 1'b1;
    step();
    in_instr = 16'h1456;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_rdy", 32'(in_ready), 32'd0);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_bund", 32'(bund), 32'(e_add));
      chk("hold_rd", 32'(out_rd), 32'd1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("release_rdy", 32'(in_ready), 32'd1);
    step();
    chk("release_bund", 32'(bund), 32'(e_sub));
    chk("release_rd", 32'(out_rd), 32'd4);
    in_valid = 1'b0;
    step(); step();

    // Flush wins over out_ready; scoreboard survives the flush
    in_instr = 16'h7310; in_valid = 1'b1;
    step();
    flush = 1'b1;
    in_instr = 16'h0456;
    #1;
    chk("flush_rdy", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    in_instr = 16'h0431;
    count_stall(n);
    chk("flush_sb_stall", 32'(n), 32'd1);
    step();
    chk("flush_after_valid", 32'(out_valid), 32'd1);
    chk("flush_after_rd", 32'(out_rd), 32'd4);
    in_valid = 1'b0;
    step(); step();

    // STR reads rd: stalls behind LDR r3
    in_instr = 16'h7300; in_valid = 1'b1;
    step();
    in_instr = 16'h9312;
    count_stall(n);
    chk("str_rd_stall", 32'(n), 32'd2);
    step();
    chk("str_mem_w", 32'(mem_w), 32'd1);
    in_valid = 1'b0;
    step(); step();

    // Reset mid-stall clears held bundle and scoreboard
    out_ready = 1'b0;
    in_instr = 16'h7310; in_valid = 1'b1;
    step();
    in_instr = 16'h0431;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_rdy", 32'(in_ready), 32'd1);
    #2;
    rst_n = 1'b1;
    step();
    chk("postrst_valid", 32'(out_valid), 32'd1);
    chk("postrst_rd", 32'(out_rd), 32'd4);
    in_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
